// File: rtl/fir_coeff_sched_pkg.sv
// Shared parameters, FSM state type and address helper for the fir_core
// coefficient scheduler.
package fir_coeff_sched_pkg;

    localparam int NTAPS       = 33;
    localparam int CW          = 16;
    localparam int AW          = 6;
    localparam int CORE_LAT    = 4;
    localparam bit CLR_ON_SWAP = 1'b1;
    localparam bit REQ_FULL    = 1'b1;

    // Cycles for the core pipeline to hold only samples filtered by the new taps.
    localparam int FLUSH_LEN = NTAPS + CORE_LAT - 1;
    localparam int CNT_W     = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SWAP,
        FLUSH
    } sched_state_t;

    function automatic logic tap_in_range(input logic [AW-1:0] a);
        return a < AW'(NTAPS);
    endfunction

endpackage

// File: rtl/fir_coeff_sched_if.sv
// Host configuration bus plus the coefficient/reset/valid lines to fir_core.
interface fir_coeff_sched_if;
    import fir_coeff_sched_pkg::*;

    logic                  cfg_we;
    logic [AW-1:0]         cfg_addr;
    logic [CW-1:0]         cfg_wdata;
    logic [AW-1:0]         cfg_raddr;
    logic [CW-1:0]         cfg_rdata;
    logic                  cfg_commit;
    logic                  cfg_busy;
    logic                  cfg_err;
    logic [NTAPS*CW-1:0]   coef_flat;
    logic                  core_rst;
    logic                  out_valid;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cfg_raddr, cfg_commit,
        input  cfg_rdata, cfg_busy, cfg_err, coef_flat, core_rst, out_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_raddr, cfg_commit,
        output cfg_rdata, cfg_busy, cfg_err, coef_flat, core_rst, out_valid
    );

endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow tap registers with written mask and registered readback, plus the
// active bank that is reloaded in one edge from the shadow on swap.
module fir_coeff_bank
    import fir_coeff_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [CW-1:0]       wdata,
    input  logic [AW-1:0]       raddr,
    output logic [CW-1:0]       rdata,
    input  logic                swap,
    output logic                mask_full,
    output logic [NTAPS*CW-1:0] coef_flat
);

    logic [CW-1:0]    shadow [NTAPS];
    logic [NTAPS-1:0] mask;
    logic [NTAPS-1:0] wr_bit;

    always_comb begin
        wr_bit = '0;
        if (we && tap_in_range(addr)) begin
            wr_bit[addr] = 1'b1;
        end
    end

    // A write landing in the commit cycle counts toward a full bank.
    assign mask_full = &(mask | wr_bit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= '0;
            end
            mask      <= '0;
            rdata     <= '0;
            coef_flat <= '0;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (wr_bit[k]) begin
                    shadow[k] <= wdata;
                end
            end
            mask  <= (swap ? '0 : mask) | wr_bit;
            rdata <= tap_in_range(raddr) ? shadow[raddr] : '0;
            if (swap) begin
                for (int k = 0; k < NTAPS; k++) begin
                    coef_flat[k*CW +: CW] <= shadow[k];
                end
            end
        end
    end

endmodule

// File: rtl/fir_coeff_sched.sv
// Commit sequencer: swaps shadow taps into the active bank, resets the core
// and holds out_valid low until the filter pipeline has refilled.
//
//  state | meaning
//  IDLE  | accepting commits; active bank stable
//  SWAP  | one cycle: active <= shadow, core_rst pulse, out_valid dropped
//  FLUSH | down-counting FLUSH_LEN..1 while the core pipeline refills
module fir_coeff_sched
    import fir_coeff_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    fir_coeff_sched_if.slave bus
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mask_full;
    logic             swap;
    logic             bad_wr;
    logic             commit_ok;
    logic             rej_commit;
    logic             flush_done;
    logic             out_valid_q;
    logic             err_q;

    assign swap       = (state == SWAP);
    assign flush_done = (flush_cnt == CNT_W'(1));
    assign bad_wr     = bus.cfg_we && !tap_in_range(bus.cfg_addr);
    assign commit_ok  = bus.cfg_commit && (state == IDLE) && (mask_full || !REQ_FULL);
    assign rej_commit = bus.cfg_commit && !commit_ok;

    fir_coeff_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (bus.cfg_we),
        .addr      (bus.cfg_addr),
        .wdata     (bus.cfg_wdata),
        .raddr     (bus.cfg_raddr),
        .rdata     (bus.cfg_rdata),
        .swap      (swap),
        .mask_full (mask_full),
        .coef_flat (bus.coef_flat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_ok) state_nxt = SWAP;
            SWAP:    state_nxt = FLUSH;
            FLUSH:   if (flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            // Bad write and rejected commit in one cycle merge into one pulse.
            err_q <= bad_wr || rej_commit;
            if (state == SWAP) begin
                flush_cnt   <= CNT_W'(FLUSH_LEN);
                out_valid_q <= 1'b0;
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - CNT_W'(1);
                if (flush_done) begin
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cfg_busy  = (state != IDLE);
    assign bus.core_rst  = CLR_ON_SWAP && swap;
    assign bus.out_valid = out_valid_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_fir_coeff_sched.sv
// Scoreboard bench for fir_coeff_sched: stimulus updates a tap-array model and
// queues timed expected events; a negedge monitor matches them against the DUT.
module tb_fir_coeff_sched;
    import fir_coeff_sched_pkg::*;

    localparam int FW              = NTAPS * CW;
    localparam int COMMIT_TO_VALID = 37;
    localparam int S_ERR = 0, S_CRST = 1, S_BUSY = 2, S_VALID = 3, S_COEF = 4, S_RD = 5;
    localparam int NS = 6;

    typedef struct {
        int            sig;
        int            cyc;
        logic [FW-1:0] val;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_coeff_sched_if bus ();

    fir_coeff_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ev_t           evq[$];
    logic [FW-1:0] exp_cur  [NS];
    logic [FW-1:0] prev_cur [NS];
    bit            mon_en   = 1'b0;
    int            n_total  = 0;
    int            n_pass   = 0;
    string         sig_name [NS] = '{"cfg_err", "core_rst", "cfg_busy", "out_valid", "coef_flat", "cfg_rdata"};

    logic [CW-1:0] m_shadow  [NTAPS];
    bit            m_written [NTAPS];
    int            m_busy_end = -1;

    function automatic logic [FW-1:0] cur_of(input int s);
        case (s)
            S_ERR:   return FW'(bus.cfg_err);
            S_CRST:  return FW'(bus.core_rst);
            S_BUSY:  return FW'(bus.cfg_busy);
            S_VALID: return FW'(bus.out_valid);
            S_COEF:  return bus.coef_flat;
            default: return FW'(bus.cfg_rdata);
        endcase
    endfunction

    task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    endtask

    function automatic void push(input int s, input int c, input logic [FW-1:0] v);
        ev_t e;
        e.sig = s;
        e.cyc = c;
        e.val = v;
        evq.push_back(e);
    endfunction

    // Pulse signals must be 1 exactly on queued cycles; level signals track the
    // latest queued value and are compared on every event or observed change.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < NS; s++) begin : per_sig
                logic [FW-1:0] cur;
                logic [FW-1:0] ex;
                bit            hit;
                cur = cur_of(s);
                hit = 1'b0;
                ex  = '0;
                for (int i = evq.size() - 1; i >= 0; i--) begin
                    if (evq[i].sig == s && evq[i].cyc == cyc) begin
                        hit = 1'b1;
                        ex  = evq[i].val;
                        evq.delete(i);
                    end
                end
                if (s == S_ERR || s == S_CRST) begin
                    if (hit || cur != '0) check(sig_name[s], cur, hit ? FW'(1) : '0);
                end else begin
                    if (hit) exp_cur[s] = ex;
                    if (hit || cur !== prev_cur[s]) check(sig_name[s], cur, exp_cur[s]);
                end
                prev_cur[s] = cur;
            end
        end
    end

    task automatic step(input bit we, input int addr, input logic [CW-1:0] wd,
                        input int raddr, input bit commit);
        int            p;
        bit            full;
        bit            bad;
        bit            rej;
        logic [FW-1:0] snap;
        @(negedge clk);
        rst_n          = 1'b1;
        bus.cfg_we     = we;
        bus.cfg_addr   = AW'(addr);
        bus.cfg_wdata  = wd;
        bus.cfg_raddr  = AW'(raddr);
        bus.cfg_commit = commit;
        p = cyc + 1;
        if (raddr < NTAPS) push(S_RD, p, FW'(m_shadow[raddr]));
        else               push(S_RD, p, '0);
        bad = we && (addr >= NTAPS);
        if (we && !bad) begin
            m_shadow[addr]  = wd;
            m_written[addr] = 1'b1;
        end
        rej = 1'b0;
        if (commit) begin
            full = 1'b1;
            foreach (m_written[k]) if (!m_written[k]) full = 1'b0;
            if (p <= m_busy_end || !full) begin
                rej = 1'b1;
            end else begin
                for (int k = 0; k < NTAPS; k++) begin
                    snap[k*CW +: CW] = m_shadow[k];
                    m_written[k]     = 1'b0;
                end
                m_busy_end = p + COMMIT_TO_VALID;
                push(S_CRST,  p,                   FW'(1));
                push(S_BUSY,  p,                   FW'(1));
                push(S_BUSY,  p + COMMIT_TO_VALID, '0);
                push(S_VALID, p + 1,               '0);
                push(S_VALID, p + COMMIT_TO_VALID, FW'(1));
                push(S_COEF,  p + 1,               snap);
            end
        end
        if (bad || rej) push(S_ERR, p, FW'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, $urandom_range(0, 40), 1'b0);
    endtask

    task automatic do_reset();
        int r;
        @(negedge clk);
        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_commit = 1'b0;
        r = cyc + 1;
        for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].cyc >= r) evq.delete(i);
        for (int k = 0; k < NTAPS; k++) begin
            m_shadow[k]  = '0;
            m_written[k] = 1'b0;
        end
        m_busy_end = -1;
        push(S_BUSY,  r, '0);
        push(S_VALID, r, '0);
        push(S_COEF,  r, '0);
        push(S_RD,    r, '0);
    endtask

    task automatic write_all(input int skip);
        for (int k = 0; k < NTAPS; k++)
            if (k != skip) step(1'b1, k, CW'($urandom), $urandom_range(0, 40), 1'b0);
    endtask

    initial begin
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_wdata  = '0;
        bus.cfg_raddr  = '0;
        bus.cfg_commit = 1'b0;
        for (int k = 0; k < NTAPS; k++) begin
            m_shadow[k]  = '0;
            m_written[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < NS; s++) begin
            check({"reset_", sig_name[s]}, cur_of(s), '0);
            prev_cur[s] = cur_of(s);
            exp_cur[s]  = '0;
        end
        mon_en = 1'b1;

        // taps k+1, commit, watch busy/core_rst/out_valid timing
        for (int k = 0; k < NTAPS; k++) step(1'b1, k, CW'(k + 1), k, 1'b0);
        step(1'b0, 0, '0, 5, 1'b1);
        idle(45);

        // incomplete bank rejected
        write_all(17);
        step(1'b0, 0, '0, 17, 1'b1);
        idle(3);

        // out-of-range write and readback; mask still missing tap 17
        step(1'b1, 40, 16'h1234, 40, 1'b0);
        step(1'b0, 0, '0, 40, 1'b0);
        step(1'b0, 0, '0, 0, 1'b1);
        step(1'b1, 17, 16'h0A5A, 17, 1'b1);

        // write and commit during FLUSH
        idle(5);
        step(1'b1, 0, 16'h7FFF, 0, 1'b0);
        step(1'b0, 0, '0, 0, 1'b1);
        step(1'b0, 0, '0, 0, 1'b0);
        idle(40);

        // last tap written in the commit cycle itself
        write_all(3);
        step(1'b1, 3, 16'h8000, 3, 1'b1);
        idle(45);

        // reset in the middle of FLUSH
        write_all(-1);
        step(1'b0, 0, '0, 0, 1'b1);
        idle(27);
        do_reset();
        idle(4);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1,
                     ($urandom_range(0, 19) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 32)),
                     CW'($urandom), $urandom_range(0, 40), $urandom_range(0, 29) == 0);
            end
        end

        idle(45);
        repeat (2) @(negedge clk);
        foreach (evq[i]) begin
            if (evq[i].cyc < cyc) begin
                n_total++;
                $display("FAIL missed_%s cyc=%0d actual=none required=%0h",
                         sig_name[evq[i].sig], evq[i].cyc, evq[i].val);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
